// File: rtl/spi_master_pkg.sv
`timescale 1ns/1ps
// spi_master_pkg: state encodings, default sizing and SPI mode constants shared
// between the SPI master and the peripheral side.
package spi_master_pkg;

  localparam logic [2:0] SPI_IDLE  = 3'd0;
  localparam logic [2:0] SPI_SETUP = 3'd1;
  localparam logic [2:0] SPI_HIGH  = 3'd2;
  localparam logic [2:0] SPI_LOW   = 3'd3;
  localparam logic [2:0] SPI_HOLD  = 3'd4;

  localparam int unsigned SPI_DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned SPI_DEFAULT_CLK_DIV    = 8;

  // Mode 0: clock idles low, data captured on the rising edge.
  localparam logic       SPI_CPOL = 1'b0;
  localparam logic       SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

endpackage

// File: rtl/spi_clk_div.sv
`timescale 1ns/1ps
// spi_clk_div: free-running 0..CLK_DIV-1 counter while enabled; tick marks the
// last count of each SCLK half-period.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
`timescale 1ns/1ps
// spi_master: SPI mode-0 master, one DATA_WIDTH-bit word per start/done handshake.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi
);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [BW-1:0]         bit_cnt;
  logic                  first_bit;
  logic                  next_bit;
  logic                  tick;

  // Counter is held clear in IDLE so every transfer starts a fresh half-period.
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (state != SPI_IDLE),
    .clr   (state == SPI_IDLE),
    .tick  (tick)
  );

  always_comb begin
`ifdef SPI_MASTER_LSB_FIRST_EN
    tx_next   = tx_shift >> 1;
    next_bit  = tx_next[0];
    first_bit = tx_data[0];
    rx_next   = {miso, rx_shift[DATA_WIDTH-1:1]};
`else
    tx_next   = tx_shift << 1;
    next_bit  = tx_next[DATA_WIDTH-1];
    first_bit = tx_data[DATA_WIDTH-1];
    rx_next   = {rx_shift[DATA_WIDTH-2:0], miso};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SPI_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SPI_IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            bit_cnt  <= '0;
            cs_n     <= 1'b0;
            mosi     <= first_bit;
            ready    <= 1'b0;
            state    <= SPI_SETUP;
          end
        end
        SPI_SETUP: begin
          if (tick) begin
            sclk     <= 1'b1;
            rx_shift <= rx_next;
            state    <= SPI_HIGH;
          end
        end
        SPI_HIGH: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= SPI_HOLD;
            end else begin
              tx_shift <= tx_next;
              mosi     <= next_bit;
              bit_cnt  <= bit_cnt + 1'b1;
              state    <= SPI_LOW;
            end
          end
        end
        SPI_LOW: begin
          if (tick) begin
            sclk     <= 1'b1;
            rx_shift <= rx_next;
            state    <= SPI_HIGH;
          end
        end
        SPI_HOLD: begin
          if (tick) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_shift;
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= SPI_IDLE;
          end
        end
        default: begin
          state <= SPI_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// tb_spi_master: directed, table-driven checks of the SPI mode-0 master with
// loopback, a falling-edge peripheral model and a synchronized far-end slave.
module tb_spi_master;
  localparam int unsigned DW = 8;
  localparam int unsigned CD = 8;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] tx_data;
  logic          ready;
  logic          done;
  logic [DW-1:0] rx_data;
  logic          miso;
  logic          sclk;
  logic          cs_n;
  logic          mosi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .ready   (ready),
    .done    (done),
    .rx_data (rx_data),
    .miso    (miso),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi)
  );

  // Peripheral: presents bit 7 while deselected, shifts left after each sclk fall.
  logic          loopback;
  logic [DW-1:0] pload;
  logic [DW-1:0] psh;
  logic          sclk_d;
  always_ff @(posedge clk) begin
    sclk_d <= sclk;
    if (cs_n) psh <= pload;
    else if (sclk_d && !sclk) psh <= psh << 1;
  end
  assign miso = loopback ? mosi : psh[DW-1];

  // Far-end slave behind 2-flop input synchronizers.
  logic [2:0]    s_sclk;
  logic [1:0]    s_cs;
  logic [1:0]    s_mosi;
  logic [DW-1:0] slave_word;
  always_ff @(posedge clk) begin
    s_sclk <= {s_sclk[1:0], sclk};
    s_cs   <= {s_cs[0], cs_n};
    s_mosi <= {s_mosi[0], mosi};
    if (!s_cs[1] && s_sclk[1] && !s_sclk[2]) slave_word <= {slave_word[DW-2:0], s_mosi[1]};
  end

  function automatic logic [DW-1:0] rev8(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input string name, input logic [DW-1:0] tx, input bit lb,
                          input logic [DW-1:0] pl, input logic [DW-1:0] exp_rx, input bit busy_poke);
    int n, cs_fall, done_at, nrise, first_rise, last_rise, last_fall, rise_bad;
    logic prev_sclk, csn_at_done, ready_busy;
    logic [DW-1:0] mbits, exp_m, rx_seen;
    cs_fall = 0; done_at = 0; nrise = 0; first_rise = 0; last_rise = 0; last_fall = 0;
    rise_bad = 0; prev_sclk = 1'b0; csn_at_done = 1'b0; ready_busy = 1'b1;
    mbits = '0; rx_seen = '0;
    for (int k = 0; k < DW; k++) exp_m[k] = LSB ? tx[k] : tx[DW-1-k];
    @(negedge clk);
    loopback = lb; pload = pl; tx_data = tx; start = 1'b1;
    @(posedge clk);
    n = 1;
    while (n <= 200 && done_at == 0) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        tx_data = ~tx;
      end
      if (busy_poke && n == 40) begin
        start = 1'b1;
        tx_data = 8'hFF;
        ready_busy = ready;
      end
      if (busy_poke && n == 41) start = 1'b0;
      if (!cs_n && cs_fall == 0) cs_fall = n;
      if (sclk && !prev_sclk) begin
        if (nrise < DW) mbits[nrise] = mosi;
        if (n != 9 + 16 * nrise) rise_bad++;
        if (nrise == 0) first_rise = n;
        last_rise = n;
        nrise++;
      end
      if (!sclk && prev_sclk) last_fall = n;
      prev_sclk = sclk;
      if (done) begin
        done_at = n;
        rx_seen = rx_data;
        csn_at_done = cs_n;
      end
      n++;
    end
    check({name, "_cs_fall"}, cs_fall, 1);
    check({name, "_nrise"}, nrise, DW);
    check({name, "_first_rise"}, first_rise, 9);
    check({name, "_last_rise"}, last_rise, 121);
    check({name, "_rise_spacing"}, rise_bad, 0);
    check({name, "_last_fall"}, last_fall, 129);
    check({name, "_mosi_bits"}, mbits, exp_m);
    check({name, "_done_at"}, done_at, 137);
    check({name, "_csn_at_done"}, csn_at_done, 1);
    check({name, "_rx"}, rx_seen, LSB && !lb ? rev8(exp_rx) : exp_rx);
    check({name, "_slave"}, slave_word, LSB ? rev8(tx) : tx);
    if (busy_poke) check({name, "_ready_busy"}, ready_busy, 0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {done, ready, cs_n, mosi, sclk}, 5'b01100);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    bit            lb;
    logic [DW-1:0] pl;
    logic [DW-1:0] rx;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d1, d2, csh, ndone;
    logic [DW-1:0] rx1, rx2;
    string nm;

    vecs[0] = '{tx: 8'hA5, lb: 1'b1, pl: 8'h00, rx: 8'hA5};
    vecs[1] = '{tx: 8'hC3, lb: 1'b0, pl: 8'h3C, rx: 8'h3C};
    vecs[2] = '{tx: 8'h5A, lb: 1'b1, pl: 8'h00, rx: 8'h5A};
    vecs[3] = '{tx: 8'h00, lb: 1'b0, pl: 8'hFF, rx: 8'hFF};
    vecs[4] = '{tx: 8'h01, lb: 1'b1, pl: 8'h00, rx: 8'h01};
    vecs[5] = '{tx: 8'hFF, lb: 1'b0, pl: 8'h6B, rx: 8'h6B};

    reset = 1'b1; start = 1'b0; tx_data = '0; loopback = 1'b1; pload = '0;
    repeat (3) @(negedge clk);
    check("reset_held_ctrl", {cs_n, sclk, mosi, ready, done}, 5'b10010);
    check("reset_held_rx", rx_data, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rel_ctrl", {cs_n, sclk, mosi, ready, done}, 5'b10010);
    check("reset_rel_rx", rx_data, 0);

    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("vec%0d", i);
      run_xfer(nm, vecs[i].tx, vecs[i].lb, vecs[i].pl, vecs[i].rx, 1'b0);
    end

    run_xfer("busy", 8'h3D, 1'b1, 8'h00, 8'h3D, 1'b1);

    // Back-to-back: start held high across the done cycle.
    @(negedge clk);
    loopback = 1'b1; tx_data = 8'h01; start = 1'b1;
    @(posedge clk);
    d1 = 0; d2 = 0; csh = 0; rx1 = '0; rx2 = '0; n = 1;
    while (n <= 400 && d2 == 0) begin
      @(negedge clk);
      if (n == 1) tx_data = 8'h80;
      if (d1 != 0 && n == d1 + 1) start = 1'b0;
      if (done) begin
        if (d1 == 0) begin d1 = n; rx1 = rx_data; end
        else begin d2 = n; rx2 = rx_data; end
      end
      if (d1 != 0 && d2 == 0 && cs_n) csh++;
      n++;
    end
    start = 1'b0;
    check("b2b_done1_at", d1, 137);
    check("b2b_done_gap", d2 - d1, 137);
    check("b2b_csn_high", csh, 1);
    check("b2b_rx1", rx1, 8'h01);
    check("b2b_rx2", rx2, 8'h80);

    // Reset in the middle of a transfer.
    @(negedge clk);
    loopback = 1'b1; tx_data = 8'hA5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (58) @(negedge clk);
    check("mid_busy_before_reset", {cs_n, ready}, 2'b00);
    reset = 1'b1;
    #1;
    check("mid_reset_ctrl", {cs_n, sclk, mosi, ready, done}, 5'b10010);
    check("mid_reset_rx", rx_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ndone = 0; csh = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!cs_n) csh++;
    end
    check("mid_reset_no_done", ndone, 0);
    check("mid_reset_cs_idle", csh, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
